cpu_control_fsm: RTL and testbench

Parametrised multicycle sequencer for the ARM datapath. It owns the PC and steps FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It adds what the current fixed-sequence control lacks:
- req/ack handshakes to instruction and data memory;
- condition-fail skip;
- branch PC update;
- bus timeout fault;
- retired-instruction counter.
It sits between the instruction/data memories, the decoder, the conditionTest/ALU/flag blocks and the register file.

---
 rtl/cpu_ctrl_pkg.sv | 18 +
 rtl/cpu_control_fsm_if.sv | 22 ++
 rtl/ctrl_timeout_counter.sv | 29 ++
 rtl/cpu_control_fsm.sv | 168 ++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and constants for the ARM multicycle sequencer.
// States, PC step sizes and default handshake timeout width.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam int PC_STEP        = 4;
  localparam int PC_PIPE_OFFSET = 8;
  localparam int DEF_TIMEOUT_W  = 4;

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Instruction/data memory handshake bundle of the sequencer.
// master = sequencer side, slave = memory side.
interface cpu_control_fsm_if;

  logic imem_req;
  logic imem_ack;
  logic ir_load;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req, ir_load, dmem_req, dmem_we,
    input  imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, ir_load, dmem_req, dmem_we,
    output imem_ack, dmem_ack
  );

endinterface

// File: rtl/ctrl_timeout_counter.sv
// Handshake wait counter; hit flags the last allowed wait cycle
// so the FSM can leave at exactly 2^TIMEOUT_W-1 waits.
module ctrl_timeout_counter #(
  parameter int TIMEOUT_W = 4
) (
  input  logic clk,
  input  logic nreset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [TIMEOUT_W-1:0] LAST =
    TIMEOUT_W'((1 << TIMEOUT_W) - 2);

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset)
      cnt_q <= '0;
    else if (clr)
      cnt_q <= '0;
    else if (en)
      cnt_q <= cnt_q + TIMEOUT_W'(1);
  end

  assign hit = (cnt_q == LAST);

endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle ARM sequencer: PC, memory handshakes, retire count.
// Optional single-step gating of FETCH under CPU_SINGLE_STEP_EN.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int OFFS_W    = 24,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W,
  parameter int CNT_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              nreset,
  cpu_control_fsm_if.master bus,
  input  logic              cond_pass,
  input  logic              is_branch,
  input  logic              is_mem,
  input  logic              is_load,
  input  logic              writes_rd,
  input  logic              set_flags,
  input  logic [OFFS_W-1:0] branch_offset,
  output logic              alu_en,
  output logic              cpsr_we,
  output logic              rf_we,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic              fault,
`ifdef CPU_SINGLE_STEP_EN
  input  logic              step_mode,
  input  logic              step_go,
`endif
  output logic [CNT_W-1:0]  instr_count
);

  state_t            st_q, st_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_seq, pc_br;
  logic              to_en, to_clr, to_hit;
  logic              fetch_go;

  assign pc_seq = pc_q + ADDR_W'(PC_STEP);
  assign pc_br  = pc_q + ADDR_W'(PC_PIPE_OFFSET)
                + (ADDR_W'(signed'(branch_offset)) << 2);

`ifdef CPU_SINGLE_STEP_EN
  logic armed_q;

  // A go pulse arms one fetch; leaving FETCH disarms.
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset)
      armed_q <= 1'b0;
    else if (st_q != S_FETCH || st_d != S_FETCH)
      armed_q <= 1'b0;
    else if (step_go)
      armed_q <= 1'b1;
  end

  assign fetch_go = ~step_mode | armed_q | step_go;
`else
  assign fetch_go = 1'b1;
`endif

  assign to_en =
    (st_q == S_FETCH && fetch_go && !bus.imem_ack) ||
    (st_q == S_MEM && !bus.dmem_ack);
  assign to_clr = (st_d != st_q);

  ctrl_timeout_counter #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timeout (
    .clk    (clk),
    .nreset (nreset),
    .clr    (to_clr),
    .en     (to_en),
    .hit    (to_hit)
  );

  always_comb begin
    st_d         = st_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    bus.imem_req = 1'b0;
    bus.ir_load  = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    alu_en       = 1'b0;
    cpsr_we      = 1'b0;
    rf_we        = 1'b0;
    unique case (st_q)
      S_FETCH: begin
        bus.imem_req = fetch_go;
        if (fetch_go && bus.imem_ack) begin
          bus.ir_load = 1'b1;
          st_d        = S_DECODE;
        end else if (fetch_go && to_hit) begin
          st_d = S_FAULT;
        end
      end
      S_DECODE: begin
        if (cond_pass) begin
          st_d = S_EXECUTE;
        end else begin
          pc_d = pc_seq;
          st_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_en  = 1'b1;
        cpsr_we = set_flags & ~is_branch;
        if (is_branch) begin
          pc_d  = pc_br;
          cnt_d = cnt_q + CNT_W'(1);
          st_d  = S_FETCH;
        end else if (is_mem) begin
          st_d = S_MEM;
        end else if (writes_rd) begin
          st_d = S_WRITEBACK;
        end else begin
          pc_d  = pc_seq;
          cnt_d = cnt_q + CNT_W'(1);
          st_d  = S_FETCH;
        end
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = ~is_load;
        if (bus.dmem_ack) begin
          if (is_load) begin
            st_d = S_WRITEBACK;
          end else begin
            pc_d  = pc_seq;
            cnt_d = cnt_q + CNT_W'(1);
            st_d  = S_FETCH;
          end
        end else if (to_hit) begin
          st_d = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        rf_we = 1'b1;
        pc_d  = pc_seq;
        cnt_d = cnt_q + CNT_W'(1);
        st_d  = S_FETCH;
      end
      S_FAULT: ;
      default: st_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      st_q  <= S_FETCH;
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign state       = st_q;
  assign fault       = (st_q == S_FAULT);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: per-instruction sequence model,
// directed cases, random instruction stream, timeout and reset.
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        cond_pass, is_branch, is_mem, is_load;
  logic        writes_rd, set_flags;
  logic [23:0] branch_offset;
  logic        alu_en, cpsr_we, rf_we, fault;
  logic [31:0] pc;
  logic [2:0]  state;
  logic [15:0] instr_count;

  always #5 clk = ~clk;

  cpu_control_fsm_if bus();

  cpu_control_fsm dut (
    .clk           (clk),
    .nreset        (nreset),
    .bus           (bus),
    .cond_pass     (cond_pass),
    .is_branch     (is_branch),
    .is_mem        (is_mem),
    .is_load       (is_load),
    .writes_rd     (writes_rd),
    .set_flags     (set_flags),
    .branch_offset (branch_offset),
    .alu_en        (alu_en),
    .cpsr_we       (cpsr_we),
    .rf_we         (rf_we),
    .pc            (pc),
    .state         (state),
    .fault         (fault),
`ifdef CPU_SINGLE_STEP_EN
    .step_mode     (1'b0),
    .step_go       (1'b0),
`endif
    .instr_count   (instr_count)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        ireq, irl, alu, cpsr;
    logic        dreq, dwe, rfwe, flt;
    logic [31:0] pc;
    logic [15:0] cnt;
  } obs_t;

  obs_t        exp_q[$];
  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic obs_t mk(input logic [2:0] st,
    input logic ireq, irl, alu, cpsr, dreq, dwe, rfwe);
    obs_t o;
    o = '{st: st, ireq: ireq, irl: irl, alu: alu, cpsr: cpsr,
          dreq: dreq, dwe: dwe, rfwe: rfwe, flt: 1'b0,
          pc: m_pc, cnt: m_cnt};
    return o;
  endfunction

  task automatic step(input logic ia, input logic da, input obs_t e);
    @(negedge clk);
    bus.imem_ack = ia;
    bus.dmem_ack = da;
    exp_q.push_back(e);
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expected cycle sequence of one instruction, from latency rules.
  task automatic run_instr(input int fw, input logic c, br, mem,
    input logic ld, wr, sf, input logic [23:0] off, input int dw);
    int so;
    cond_pass = c; is_branch = br; is_mem = mem; is_load = ld;
    writes_rd = wr; set_flags = sf; branch_offset = off;
    for (int i = 0; i < fw; i++)
      step(1'b0, rb(), mk(3'd0, 1, 0, 0, 0, 0, 0, 0));
    step(1'b1, rb(), mk(3'd0, 1, 1, 0, 0, 0, 0, 0));
    step(rb(), rb(), mk(3'd1, 0, 0, 0, 0, 0, 0, 0));
    if (!c) begin
      m_pc = m_pc + 32'd4;
    end else begin
      step(rb(), rb(), mk(3'd2, 0, 0, 1, sf & ~br, 0, 0, 0));
      if (br) begin
        so = (off >= 24'h800000) ? int'(off) - 32'h1000000
                                 : int'(off);
        m_pc = m_pc + 32'(8 + 4 * so);
      end else begin
        if (mem) begin
          for (int i = 0; i < dw; i++)
            step(rb(), 1'b0, mk(3'd3, 0, 0, 0, 0, 1, ~ld, 0));
          step(rb(), 1'b1, mk(3'd3, 0, 0, 0, 0, 1, ~ld, 0));
          if (ld)
            step(rb(), rb(), mk(3'd4, 0, 0, 0, 0, 0, 0, 1));
        end else if (wr) begin
          step(rb(), rb(), mk(3'd4, 0, 0, 0, 0, 0, 0, 1));
        end
        m_pc = m_pc + 32'd4;
      end
      m_cnt = m_cnt + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  // Compare process: one check per modelled cycle.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state, bus.imem_req, bus.ir_load, alu_en, cpsr_we,
             bus.dmem_req, bus.dmem_we, rf_we, fault, pc,
             instr_count};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL cycle t=%0t got %h want %h",
                   $time, a, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, n;
    logic ld, mem, wr, br;
    cond_pass = 0; is_branch = 0; is_mem = 0; is_load = 0;
    writes_rd = 0; set_flags = 0; branch_offset = '0;
    bus.imem_ack = 0; bus.dmem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_pc", pc, 32'd0);
    chk("reset_count", 32'(instr_count), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    nreset = 0;
    m_pc = 0; m_cnt = 0;

    run_instr(0, 1, 0, 0, 0, 1, 0, 24'd0, 0);
    chk("alu_wb_pc", pc, 32'h4);
    chk("alu_wb_count", 32'(instr_count), 32'd1);
    run_instr(1, 1, 0, 0, 0, 0, 1, 24'd0, 0);
    run_instr(0, 1, 0, 1, 0, 0, 0, 24'd0, 1);
    run_instr(0, 1, 0, 1, 1, 0, 0, 24'd0, 3);
    chk("load_pc", pc, 32'h10);
    run_instr(2, 0, 0, 0, 0, 1, 1, 24'd0, 0);
    chk("condfail_pc", pc, 32'h14);
    chk("condfail_count", 32'(instr_count), 32'd4);
    run_instr(0, 1, 1, 0, 0, 0, 0, 24'd1, 0);
    chk("branch_fwd_pc", pc, 32'h20);
    run_instr(0, 1, 1, 0, 0, 0, 1, 24'hFFFFFE, 0);
    chk("branch_self_pc", pc, 32'h20);
    run_instr(0, 1, 1, 0, 0, 0, 1, 24'd3, 0);
    chk("branch_3_pc", pc, 32'h34);
    chk("branch_count", 32'(instr_count), 32'd7);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 4);
      br = (kind == 4);
      mem = br ? rb() : (kind == 2 || kind == 3);
      ld = (kind == 2) ? 1'b1 : (kind == 3) ? 1'b0 : rb();
      wr = (kind == 1) ? 1'b1 : (kind == 0) ? 1'b0 : rb();
      run_instr($urandom_range(0, 4), ($urandom_range(0, 3) != 0),
                br, mem, ld, wr, rb(), 24'($urandom),
                $urandom_range(0, 5));
    end

    // Async reset in the middle of a data handshake.
    cond_pass = 1; is_branch = 0; is_mem = 1; is_load = 0;
    n = 0;
    @(negedge clk);
    bus.imem_ack = 1; bus.dmem_ack = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (bus.dmem_req) break;
    end
    chk("mem_reached", 32'(bus.dmem_req), 32'd1);
    nreset = 1;
    #1;
    chk("midmem_dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("midmem_pc", pc, 32'd0);
    chk("midmem_state", 32'(state), 32'd0);

    // Fetch timeout into sticky FAULT.
    bus.imem_ack = 0;
    @(posedge clk);
    #1;
    nreset = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (state == 3'd5) break;
      if (state == 3'd0) n++;
    end
    chk("timeout_cycles", 32'(n), 32'd15);
    chk("fault_set", 32'(fault), 32'd1);
    bus.imem_ack = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("fault_sticky", 32'(fault), 32'd1);
    chk("fault_state", 32'(state), 32'd5);
    chk("fault_no_req", 32'(bus.imem_req), 32'd0);
    #2;
    nreset = 1;
    #1;
    chk("fault_reset_state", 32'(state), 32'd0);
    chk("fault_reset_fault", 32'(fault), 32'd0);
    chk("fault_reset_pc", pc, 32'd0);
    bus.imem_ack = 0;
    @(posedge clk);
    #1;
    nreset = 0;
    m_pc = 0; m_cnt = 0;
    run_instr(1, 1, 0, 0, 0, 1, 0, 24'd0, 0);
    chk("recover_pc", pc, 32'h4);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
